// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side direction/target predictor.
// A direct-mapped BTB (valid, tag, target) indexed by pc[INDEX_W+1:2] is
// paired with 2-bit saturating counters (00 strong NT .. 11 strong T).
// Lookup for if_pc is purely combinational from registered state, so there
// is no path from the ex_* inputs to pred_*. A resolved conditional branch
// in EX (ex_Branch = 1) trains the tables on the rising edge; a same-cycle
// lookup of the same index therefore sees the pre-update entry.
// A free-running 32-bit counter tallies direction mispredictions.
//
// Optional build macro BP_GSHARE_EN: counters move into a separate pattern
// history table indexed by idx ^ global history; the history register is
// exported as if_ghr, and the history seen at fetch returns as ex_ghr.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        if_pc,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    input  logic               ex_Branch,
    input  logic [31:0]        ex_pc,
    input  logic               ex_take_branch,
    input  logic [31:0]        ex_target,
    input  logic               ex_pred_taken,
    output logic [31:0]        mispredict_cnt
`ifdef BP_GSHARE_EN
    ,
    output logic [INDEX_W-1:0] if_ghr,
    input  logic [INDEX_W-1:0] ex_ghr
`endif
);

    localparam int TAG_W = 32 - INDEX_W - 2;

    // Saturating step of a 2-bit direction counter.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'd1;
        end
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // BTB storage (flops, so reset clears every entry in one cycle).
    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        mispredict_q;
    logic [31:0]        mispredict_d;

    // EX-side decode and next values for the single BTB entry being trained.
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_hit;
    logic               btb_we;
    logic               valid_d;
    logic [TAG_W-1:0]   tag_d;
    logic [31:0]        target_d;

    // IF-side lookup.
    logic [INDEX_W-1:0] if_idx;
    logic               if_hit;
    logic [1:0]         if_ctr;

    // Address bits [1:0] never take part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [1:0]         pht_q [ENTRIES];
    logic [INDEX_W-1:0] ghr_q;
    logic [INDEX_W-1:0] ghr_d;
    logic [INDEX_W-1:0] pht_idx;
    logic [1:0]         pht_d;
    logic [INDEX_W:0]   ghr_shift;
`else
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d;
`endif

    // Compute the write-back for the EX branch's BTB entry (and counter).
    always_comb begin
        ex_idx   = ex_pc[INDEX_W+1:2];
        ex_tag   = ex_pc[31:INDEX_W+2];
        ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        btb_we   = 1'b0;
        valid_d  = valid_q[ex_idx];
        tag_d    = tag_q[ex_idx];
        target_d = target_q[ex_idx];
`ifndef BP_GSHARE_EN
        ctr_d    = ctr_q[ex_idx];
`endif
        if (ex_Branch) begin
            if (ex_hit) begin
                // Hit: train the counter; a taken outcome refreshes the target.
                btb_we = 1'b1;
                if (ex_take_branch) begin
                    target_d = ex_target;
                end
`ifndef BP_GSHARE_EN
                ctr_d = sat_step(ctr_q[ex_idx], ex_take_branch);
`endif
            end else if (ex_take_branch) begin
                // Taken miss: allocate or replace, starting at weak taken.
                btb_we   = 1'b1;
                valid_d  = 1'b1;
                tag_d    = ex_tag;
                target_d = ex_target;
`ifndef BP_GSHARE_EN
                ctr_d    = 2'b10;
`endif
            end
            // Not-taken miss leaves the BTB untouched.
        end
    end

`ifdef BP_GSHARE_EN
    // PHT entry selected by the history the branch saw at fetch; history shifts in the outcome.
    always_comb begin
        pht_idx   = ex_idx ^ ex_ghr;
        pht_d     = sat_step(pht_q[pht_idx], ex_take_branch);
        ghr_shift = {ghr_q, ex_take_branch};
        ghr_d     = ghr_shift[INDEX_W-1:0];
    end
`endif

    // Event counter: one per resolved branch whose direction was mispredicted.
    always_comb begin
        mispredict_d = mispredict_q
                     + {31'd0, ex_Branch && (ex_pred_taken != ex_take_branch)};
    end

    // Table and counter state; reset wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
`ifdef BP_GSHARE_EN
                pht_q[i]    <= 2'b01;
`else
                ctr_q[i]    <= 2'b01;
`endif
            end
            mispredict_q <= '0;
`ifdef BP_GSHARE_EN
            ghr_q        <= '0;
`endif
        end else begin
            if (btb_we) begin
                valid_q[ex_idx]  <= valid_d;
                tag_q[ex_idx]    <= tag_d;
                target_q[ex_idx] <= target_d;
`ifndef BP_GSHARE_EN
                ctr_q[ex_idx]    <= ctr_d;
`endif
            end
`ifdef BP_GSHARE_EN
            if (ex_Branch) begin
                pht_q[pht_idx] <= pht_d;
                ghr_q          <= ghr_d;
            end
`endif
            mispredict_q <= mispredict_d;
        end
    end

    // Zero-latency lookup for the fetch PC from registered state only.
    always_comb begin
        if_idx = if_pc[INDEX_W+1:2];
        if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_pc[31:INDEX_W+2]);
`ifdef BP_GSHARE_EN
        if_ctr = pht_q[if_idx ^ ghr_q];
`else
        if_ctr = ctr_q[if_idx];
`endif
        pred_taken  = if_hit && if_ctr[1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    end

    assign mispredict_cnt = mispredict_q;
`ifdef BP_GSHARE_EN
    assign if_ghr = ghr_q;
`endif

endmodule
